// File: rtl/rgbw_frame_ctrl.sv
// rtl/rgbw_frame_ctrl.sv - SPI byte-stream frame receiver driving committed RGBW PWM duty registers
// Optional macro RGBW_FRAME_CHKSUM_EN: when defined, frames with a bad checksum byte are rejected.
module rgbw_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic [7:0] red_duty,
  output logic [7:0] green_duty,
  output logic [7:0] blue_duty,
  output logic [7:0] white_duty,
  output logic [7:0] intensity,
  output logic [7:0] mode,
  output logic       update,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK, COMMIT} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [7:0]    shadow [0:7];
  logic          chk_ok;

  // Slot 1..6 hold intensity, mode, R, G, B, W; slot 7 holds the checksum byte.
`ifdef RGBW_FRAME_CHKSUM_EN
  logic [7:0] chk_calc;

  // Checksum seeded with 0x80 so an all-zero payload does not carry a zero checksum.
  always_comb begin
    chk_calc = 8'h80 ^ shadow[1] ^ shadow[2] ^ shadow[3] ^ shadow[4] ^ shadow[5] ^ shadow[6];
    chk_ok   = (chk_calc == shadow[7]);
  end
`else
  assign chk_ok = 1'b1;
`endif

  assign timer_nxt = timer + 1'b1;
  assign busy      = (state != IDLE);

  // Frame state machine: collect into shadow slots, validate, then commit to outputs in one cycle.
  always_ff @(posedge clk12) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      timer      <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
      red_duty   <= 8'h00;
      green_duty <= 8'h00;
      blue_duty  <= 8'h00;
      white_duty <= 8'h00;
      intensity  <= 8'h00;
      mode       <= 8'h00;
      update     <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_rdy && (rx_data == SYNC_BYTE)) begin
            state <= RECV;
            idx   <= 3'd1;
          end
        end
        RECV: begin
          if (rx_rdy) begin
            // A sync value inside a frame is plain data; no resynchronisation.
            shadow[idx] <= rx_data;
            idx         <= idx + 3'd1;
            timer       <= '0;
            if (idx == 3'd7) state <= CHECK;
          end else if (timer_nxt == TIMER_LAST) begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
            idx   <= 3'd0;
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer_nxt;
          end
        end
        CHECK: begin
          timer <= '0;
          if (chk_ok) begin
            state <= COMMIT;
          end else begin
            frame_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= IDLE;
          end
        end
        COMMIT: begin
          timer      <= '0;
          intensity  <= shadow[1];
          mode       <= shadow[2];
          red_duty   <= shadow[3];
          green_duty <= shadow[4];
          blue_duty  <= shadow[5];
          white_duty <= shadow[6];
          update     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgbw_frame_ctrl.sv
// tb/tb_rgbw_frame_ctrl.sv - self-checking bench for rgbw_frame_ctrl against a frame-level model
module tb_rgbw_frame_ctrl;

  localparam int T = 16;

  logic       r_Clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] red_duty, green_duty, blue_duty, white_duty, intensity, mode, err_count;
  logic       update, frame_err, busy;

  rgbw_frame_ctrl #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(T)) dut (
    .clk12(r_Clk), .reset(reset), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .red_duty(red_duty), .green_duty(green_duty), .blue_duty(blue_duty), .white_duty(white_duty),
    .intensity(intensity), .mode(mode), .update(update), .frame_err(frame_err),
    .err_count(err_count), .busy(busy)
  );

  always #5 r_Clk = ~r_Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_on = 1'b0;
  int upd_seen = 0, ferr_seen = 0, upd_cyc = -1, ferr_cyc = -1, last_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge r_Clk);
    cyc++;
  end

  // Frame-level model: a queue of collected bytes, a quiet-cycle count and a post-frame stall.
  logic [7:0] q[$];
  logic [7:0] held [8];
  logic [7:0] xs;
  int  quiet = 0, stall = 0;
  bit  pend_ok = 1'b0;
  logic [7:0] e_int = 0, e_mode = 0, e_r = 0, e_g = 0, e_b = 0, e_w = 0, e_cnt = 0;
  bit  e_upd = 0, e_ferr = 0, e_busy = 0;

  initial forever begin
    @(posedge r_Clk);
    e_upd  = 1'b0;
    e_ferr = 1'b0;
    if (reset) begin
      q.delete();
      quiet = 0; stall = 0;
      e_int = 0; e_mode = 0; e_r = 0; e_g = 0; e_b = 0; e_w = 0; e_cnt = 0;
    end else if (stall > 0) begin
      stall--;
      if (stall == 0) begin
        if (pend_ok) begin
          e_int = held[1]; e_mode = held[2]; e_r = held[3];
          e_g = held[4]; e_b = held[5]; e_w = held[6];
          e_upd = 1'b1;
        end else begin
          e_ferr = 1'b1;
          if (e_cnt != 8'hFF) e_cnt++;
        end
      end
    end else if (q.size() > 0) begin
      if (rx_rdy) begin
        q.push_back(rx_data);
        quiet = 0;
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) held[i] = q[i];
          q.delete();
`ifdef RGBW_FRAME_CHKSUM_EN
          xs = 8'h80;
          for (int i = 1; i < 7; i++) xs ^= held[i];
          pend_ok = (xs == held[7]);
`else
          pend_ok = 1'b1;
`endif
          stall = pend_ok ? 2 : 1;
        end
      end else begin
        quiet++;
        if (quiet == T - 1) begin
          q.delete();
          e_ferr = 1'b1;
          if (e_cnt != 8'hFF) e_cnt++;
        end
      end
    end else if (rx_rdy && rx_data == 8'h55) begin
      q.push_back(rx_data);
      quiet = 0;
    end
    e_busy = (q.size() > 0) || (stall > 0);
  end

  // Compare every cycle, mid-period, against the model.
  initial forever begin
    @(negedge r_Clk);
    if (cmp_on) begin
      check("update", update, e_upd);
      check("frame_err", frame_err, e_ferr);
      check("busy", busy, e_busy);
      check("intensity", intensity, e_int);
      check("mode", mode, e_mode);
      check("red", red_duty, e_r);
      check("green", green_duty, e_g);
      check("blue", blue_duty, e_b);
      check("white", white_duty, e_w);
      check("err_count", err_count, e_cnt);
      if (update) begin upd_seen++; upd_cyc = cyc; end
      if (frame_err) begin ferr_seen++; ferr_cyc = cyc; end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge r_Clk); #1;
    rx_rdy = 1'b1; rx_data = b; last_cyc = cyc;
    @(posedge r_Clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [8]);
    for (int i = 0; i < 8; i++) send_byte(f[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge r_Clk);
    #1;
  endtask

  task automatic clear_seen();
    upd_seen = 0; ferr_seen = 0; upd_cyc = -1; ferr_cyc = -1;
  endtask

  logic [7:0] f1 [8] = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4};
  logic [7:0] f2 [8] = '{8'h55, 8'hFF, 8'h23, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4};
  logic [7:0] f3 [8] = '{8'h55, 8'h10, 8'h01, 8'h20, 8'h30, 8'h40, 8'h50, 8'h91};
  logic [7:0] f4 [8] = '{8'h55, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hD4};

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge r_Clk);
    #1 reset = 1'b0;
    cmp_on = 1'b1;
    @(negedge r_Clk);
    check("rst_busy", busy, 0);
    check("rst_intensity", intensity, 0);
    check("rst_err_count", err_count, 0);

    // Valid frame
    clear_seen();
    send_frame(f1);
    idle(5);
    check("f1_intensity", intensity, 8'hFF);
    check("f1_mode", mode, 8'h24);
    check("f1_red", red_duty, 8'h00);
    check("f1_green", green_duty, 8'hFF);
    check("f1_blue", blue_duty, 8'h00);
    check("f1_white", white_duty, 8'h00);
    check("f1_updates", upd_seen, 1);
    check("f1_latency", upd_cyc - last_cyc, 3);
    check("f1_err_count", err_count, 0);

    // Bad checksum frame
    clear_seen();
    send_frame(f2);
    idle(5);
`ifdef RGBW_FRAME_CHKSUM_EN
    check("f2_frame_err", ferr_seen, 1);
    check("f2_err_count", err_count, 1);
    check("f2_mode_held", mode, 8'h24);
    check("f2_updates", upd_seen, 0);
`else
    check("f2_frame_err", ferr_seen, 0);
    check("f2_mode", mode, 8'h23);
    check("f2_updates", upd_seen, 1);
`endif

    // Timeout after 3 bytes, then a valid frame
    clear_seen();
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02);
    idle(T + 4);
    check("to_frame_err", ferr_seen, 1);
    check("to_latency", ferr_cyc - last_cyc, T);
    check("to_busy", busy, 0);
    check("to_updates", upd_seen, 0);
    clear_seen();
    send_frame(f3);
    idle(5);
    check("f3_intensity", intensity, 8'h10);
    check("f3_red", red_duty, 8'h20);
    check("f3_white", white_duty, 8'h50);
    check("f3_updates", upd_seen, 1);

    // Leading garbage bytes then a valid frame
    clear_seen();
    send_byte(8'h00); send_byte(8'h12);
    send_frame(f1);
    idle(5);
    check("lead_frame_err", ferr_seen, 0);
    check("lead_updates", upd_seen, 1);
    check("lead_intensity", intensity, 8'hFF);
    check("lead_mode", mode, 8'h24);

    // Sync value as payload, then a sync byte landing in COMMIT is dropped
    clear_seen();
    send_frame(f4);
    send_byte(8'h55);
    idle(4);
    check("f4_intensity", intensity, 8'h55);
    check("f4_mode", mode, 8'h01);
    check("f4_updates", upd_seen, 1);
    check("f4_drop_busy", busy, 0);
    idle(T + 2);

    // Reset after byte 4, with a concurrent sync byte, then the tail of the frame
    clear_seen();
    send_byte(8'h55); send_byte(8'hFF); send_byte(8'h24); send_byte(8'h00);
    @(posedge r_Clk); #1;
    reset = 1'b1; rx_rdy = 1'b1; rx_data = 8'h55;
    @(posedge r_Clk); #1;
    reset = 1'b0; rx_rdy = 1'b0;
    send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00); send_byte(8'hA4);
    idle(T + 4);
    check("rst_mid_intensity", intensity, 0);
    check("rst_mid_green", green_duty, 0);
    check("rst_mid_err_count", err_count, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_updates", upd_seen, 0);
    check("rst_mid_frame_err", ferr_seen, 0);

    // 300 rejected frames saturate the error counter
    clear_seen();
    repeat (300) begin
      send_byte(8'h55);
      idle(T + 1);
    end
    check("sat_frame_errs", ferr_seen, 300);
    check("sat_err_count", err_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgbw_frame_ctrl.md
RGBW_FRAME_CTRL -- requirements
Module: rgbw_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h55, the required first byte of every frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, the maximum clk12 cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk12, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_rdy, input, 1 bit: one-cycle pulse from the SPI slave marking a new valid rx_data byte.
REQ-006 SHALL have port rx_data, input, 8 bits: the received SPI byte, valid while rx_rdy is high.
REQ-007 SHALL have ports red_duty, green_duty, blue_duty and white_duty, output, 8 bits each: committed PWM duty values.
REQ-008 SHALL have port intensity, output, 8 bits: committed global intensity.
REQ-009 SHALL have port mode, output, 8 bits: committed mode byte.
REQ-010 SHALL have port update, output, 1 bit: one-cycle pulse marking a new commit.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking a rejected frame.
REQ-012 SHALL have port err_count, output, 8 bits: count of rejected frames, saturating.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL use the 8-byte frame format: SYNC, intensity, mode, R, G, B, W, checksum.
REQ-015 SHALL define the checksum as 8'h80 XOR bytes 1 through 6.
REQ-016 SHALL implement the states IDLE, RECV, CHECK and COMMIT.
REQ-017 SHALL, in IDLE, move to RECV on rx_rdy with rx_data == SYNC_BYTE, clearing the byte index to 1.
REQ-018 SHALL, in IDLE, drop any non-sync byte silently (no frame_err, no count).
REQ-019 SHALL, in RECV, store each rx_rdy byte into shadow slot[index] and increment the 3-bit index.
REQ-020 SHALL, in RECV, move to CHECK on the rx_rdy that stores byte 7.
REQ-021 SHALL, in RECV, treat a byte equal to SYNC_BYTE as ordinary data, with no resynchronisation.
REQ-022 SHALL keep shadow registers separate from the outputs, so outputs never show a partial frame.
REQ-023 SHALL, in CHECK (one cycle), compare the received checksum against the accumulated XOR.
REQ-024 SHALL go from CHECK to COMMIT on a checksum match.
REQ-025 SHALL, on a checksum mismatch, pulse frame_err, increment err_count, and return to IDLE.
REQ-026 SHALL, in COMMIT (one cycle), copy the shadow registers to the outputs, pulse update, and return to IDLE.
REQ-027 SHALL make outputs and update visible in the third cycle after the byte-7 rx_rdy cycle.
REQ-028 SHALL drop an rx_rdy arriving in CHECK or COMMIT without side effects.
REQ-029 SHALL clear the inter-byte timer on every rx_rdy and run it only while in RECV.
REQ-030 SHALL, when the timer reaches TIMEOUT_CYCLES-1 with no rx_rdy, pulse frame_err, increment err_count, discard the shadow data, and return to IDLE.
REQ-031 SHALL ignore a timeout and an rx_rdy in the same cycle in favour of the rx_rdy.
REQ-032 SHALL saturate err_count at 8'hFF with no wrap-around.
REQ-033 SHALL hold the outputs unchanged after a rejected frame.

Reset
REQ-034 SHALL, on reset, clear every output to 0 and set the state to IDLE.
REQ-035 SHALL, on reset, clear the index, timer and shadow registers.
REQ-036 SHALL, on reset asserted mid-frame, abort the frame with no update and no frame_err pulse.
REQ-037 SHALL take priority for reset over any concurrent rx_rdy.

Configuration
REQ-038 SHALL, with macro RGBW_FRAME_CHKSUM_EN defined, perform the checksum comparison in CHECK as above.
REQ-039 SHALL, without RGBW_FRAME_CHKSUM_EN, store byte 7 but not compare it; CHECK always proceeds to COMMIT, and frame_err and err_count change only on timeout.

Verification
REQ-040 SHALL verify valid frame 55 FF 24 00 FF 00 00 A4 -> intensity=FF, mode=24, R=00, G=FF, B=00, W=00, one update pulse, err_count=0.
REQ-041 SHALL verify bad-checksum frame 55 FF 23 00 FF 00 00 A4 (macro on) -> frame_err pulse, err_count=1, outputs unchanged; with the macro off -> update with mode=23.
REQ-042 SHALL verify 3 bytes then a TIMEOUT_CYCLES silence -> frame_err pulse after exactly TIMEOUT_CYCLES-1 idle cycles, busy low; a following valid frame commits normally.
REQ-043 SHALL verify leading bytes 00 12 then a valid frame -> no frame_err, a single update with the valid frame's values.
REQ-044 SHALL verify reset after byte 4 of a frame -> all outputs 0, busy 0, no update; the remaining bytes are treated as non-sync and dropped.
REQ-045 SHALL verify 300 bad frames -> err_count saturates at FF.
